// File: rtl/mem_arbiter_pkg.sv
// Shared types, constants and state encoding for the byte-serial memory arbiter.
package mem_arbiter_pkg;

  localparam int WORD_W = 32;

  typedef logic [31:0]       addr_t;
  typedef logic [WORD_W-1:0] word_t;

  localparam logic  TRUE      = 1'b1;
  localparam logic  FALSE     = 1'b0;
  localparam word_t ZERO_WORD = 32'h0000_0000;
  localparam addr_t ZERO_ADDR = 32'h0000_0000;

  // A fetch is always a full word, encoded like a load of len 3.
  localparam logic [3:0] FETCH_LEN = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LOAD  = 2'd2,
    ST_STORE = 2'd3
  } state_e;

  function automatic logic [7:0] word_byte(input word_t w, input logic [1:0] idx);
    word_byte = w[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/load_extender.sv
// Narrows an assembled little-endian load word to its access size and applies
// sign or zero extension.
module load_extender
  import mem_arbiter_pkg::*;
(
  input  word_t      raw_i,
  input  logic [3:0] len_i,
  input  logic       sext_i,
  output word_t      ext_o
);

  // Byte and halfword results replicate their top bit only when sext is set.
  always_comb begin
    ext_o = raw_i;
    case (len_i)
      4'd0:    ext_o = {{24{sext_i & raw_i[7]}}, raw_i[7:0]};
      4'd1:    ext_o = {{16{sext_i & raw_i[15]}}, raw_i[15:0]};
      default: ext_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the byte-wide RAM/IO port between fetch, load and store requesters,
// serialising each access into byte transactions and pulsing a done per requester.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_HI  = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              rb,
  input  logic              if_ena,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output word_t             if_data,
  input  logic              ld_ena,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [3:0]        ld_len,
  input  logic              ld_sext,
  output logic              ld_done,
  output word_t             ld_data,
  input  logic              st_ena,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [3:0]        st_len,
  input  word_t             st_data,
  output logic              st_done,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        len_q, len_d;
  logic              sext_q, sext_d;
  word_t             sdata_q, sdata_d;
  word_t             buf_q, buf_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]        dout_q, dout_d;
  logic              wr_q, wr_d;
  logic              if_done_q, if_done_d;
  logic              ld_done_q, ld_done_d;
  logic              st_done_q, st_done_d;
  word_t             if_data_q, if_data_d;
  word_t             ld_data_q, ld_data_d;

  logic              any_done_s;
  logic              read_last_s;
  logic              store_end_s;
  logic              store_io_s;
  logic              grant_io_stall_s;
  logic [ADDR_W-1:0] cur_off_s;
  logic [ADDR_W-1:0] next_off_s;
  word_t             assembled_s;
  word_t             ext_s;

  assign any_done_s       = if_done_q | ld_done_q | st_done_q;
  assign read_last_s      = ({1'b0, cnt_q} == len_q);
  assign store_end_s      = ({1'b0, cnt_q} > len_q);
  assign store_io_s       = (addr_q[17:16] == IO_HI);
  assign grant_io_stall_s = (st_addr[17:16] == IO_HI) & io_buffer_full;
  assign cur_off_s        = {{(ADDR_W-3){1'b0}}, cnt_q};
  assign next_off_s       = {{(ADDR_W-3){1'b0}}, cnt_q + 3'd1};
  // mem_din answers the address driven on the previous edge, i.e. byte cnt_q.
  assign assembled_s      = buf_q | ({24'h00_0000, mem_din} << {cnt_q[1:0], 3'b000});

  load_extender u_load_extender (
    .raw_i  (assembled_s),
    .len_i  (len_q),
    .sext_i (sext_q),
    .ext_o  (ext_s)
  );

  // Next-state and registered-output logic for grant, read assembly and store streaming.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    len_d     = len_q;
    sext_d    = sext_q;
    sdata_d   = sdata_q;
    buf_d     = buf_q;
    mem_a_d   = mem_a_q;
    dout_d    = dout_q;
    wr_d      = FALSE;
    if_done_d = FALSE;
    ld_done_d = FALSE;
    st_done_d = FALSE;
    if_data_d = if_data_q;
    ld_data_d = ld_data_q;

    case (state_q)
      ST_IDLE: begin
        if (any_done_s) begin
          state_d = ST_IDLE;
        end else if (st_ena) begin
          state_d = ST_STORE;
          addr_d  = st_addr;
          len_d   = st_len;
          sdata_d = st_data;
          mem_a_d = st_addr;
          if (grant_io_stall_s) begin
            cnt_d = 3'd0;
          end else begin
            dout_d = st_data[7:0];
            wr_d   = TRUE;
            cnt_d  = 3'd1;
          end
        end else if (!rb && ld_ena) begin
          state_d = ST_LOAD;
          addr_d  = ld_addr;
          len_d   = ld_len;
          sext_d  = ld_sext;
          mem_a_d = ld_addr;
          cnt_d   = 3'd0;
          buf_d   = ZERO_WORD;
        end else if (!rb && if_ena) begin
          state_d = ST_FETCH;
          addr_d  = if_addr;
          len_d   = FETCH_LEN;
          sext_d  = FALSE;
          mem_a_d = if_addr;
          cnt_d   = 3'd0;
          buf_d   = ZERO_WORD;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_FETCH, ST_LOAD: begin
        if (rb) begin
          state_d = ST_IDLE;
          mem_a_d = ADDR_ZERO;
          cnt_d   = 3'd0;
        end else if (read_last_s) begin
          state_d = ST_IDLE;
          mem_a_d = ADDR_ZERO;
          cnt_d   = 3'd0;
          buf_d   = assembled_s;
          if (state_q == ST_FETCH) begin
            if_done_d = TRUE;
            if_data_d = assembled_s;
          end else begin
            ld_done_d = TRUE;
            ld_data_d = ext_s;
          end
        end else begin
          buf_d   = assembled_s;
          cnt_d   = cnt_q + 3'd1;
          mem_a_d = addr_q + next_off_s;
        end
      end

      ST_STORE: begin
        // Here cnt_q is the next byte to drive; a full IO sink parks it on the bus.
        if (store_end_s) begin
          state_d   = ST_IDLE;
          cnt_d     = 3'd0;
          st_done_d = TRUE;
        end else if (store_io_s && io_buffer_full) begin
          mem_a_d = addr_q + cur_off_s;
        end else begin
          mem_a_d = addr_q + cur_off_s;
          dout_d  = word_byte(sdata_q, cnt_q[1:0]);
          wr_d    = TRUE;
          cnt_d   = cnt_q + 3'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // State and output registers; everything freezes while rdy is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 3'd0;
      addr_q    <= ADDR_ZERO;
      len_q     <= 4'd0;
      sext_q    <= 1'b0;
      sdata_q   <= ZERO_WORD;
      buf_q     <= ZERO_WORD;
      mem_a_q   <= ADDR_ZERO;
      dout_q    <= 8'h00;
      wr_q      <= 1'b0;
      if_done_q <= 1'b0;
      ld_done_q <= 1'b0;
      st_done_q <= 1'b0;
      if_data_q <= ZERO_WORD;
      ld_data_q <= ZERO_WORD;
    end else if (rdy) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      sext_q    <= sext_d;
      sdata_q   <= sdata_d;
      buf_q     <= buf_d;
      mem_a_q   <= mem_a_d;
      dout_q    <= dout_d;
      wr_q      <= wr_d;
      if_done_q <= if_done_d;
      ld_done_q <= ld_done_d;
      st_done_q <= st_done_d;
      if_data_q <= if_data_d;
      ld_data_q <= ld_data_d;
    end
  end

  assign mem_a    = mem_a_q;
  assign mem_dout = dout_q;
  assign mem_wr   = wr_q & rdy;
  assign if_done  = if_done_q;
  assign ld_done  = ld_done_q;
  assign st_done  = st_done_q;
  assign if_data  = if_data_q;
  assign ld_data  = ld_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario-driven bench for mem_arbiter: directed timing checks plus randomized
// requests scored against a byte-array memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy, rb;
  logic        if_ena, if_done, ld_ena, ld_sext, ld_done, st_ena, st_done;
  logic [31:0] if_addr, if_data, ld_addr, ld_data, st_addr, st_data, mem_a;
  logic [3:0]  ld_len, st_len;
  logic [7:0]  mem_din, mem_dout;
  logic        mem_wr, io_buffer_full;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  ram [0:1023];
  logic [39:0] wlog [$];

  always #5 clk = ~clk;

  assign mem_din = ram[mem_a[9:0]];

  always @(posedge clk) begin
    if (mem_wr === 1'b1) wlog.push_back({mem_a, mem_dout});
  end

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rb(rb),
    .if_ena(if_ena), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ld_ena(ld_ena), .ld_addr(ld_addr), .ld_len(ld_len), .ld_sext(ld_sext),
    .ld_done(ld_done), .ld_data(ld_data),
    .st_ena(st_ena), .st_addr(st_addr), .st_len(st_len), .st_data(st_data),
    .st_done(st_done),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: little-endian bytes from the model RAM, then arithmetic extension.
  function automatic logic [31:0] exp_load(input logic [31:0] a, input int nbytes, input logic sext);
    longint v;
    v = 0;
    for (int i = 0; i < nbytes; i++)
      v = v + longint'(ram[(int'(a) + i) % 1024]) * (longint'(1) << (8 * i));
    if (sext && nbytes < 4 && v >= (longint'(1) << (8 * nbytes - 1)))
      v = v - (longint'(1) << (8 * nbytes));
    return v[31:0];
  endfunction

  // kind: 0 fetch, 1 load, 2 store. Waits (bounded) for the matching done.
  task automatic run_req(input int kind, input logic [31:0] a, input logic [3:0] len,
                         input logic sext, input logic [31:0] d, input bit rand_rdy,
                         output logic [31:0] data, output int lat, output bit ok);
    ok = 1'b0; lat = 0; data = 32'h0;
    case (kind)
      0:       begin if_addr = a; if_ena = 1'b1; end
      1:       begin ld_addr = a; ld_len = len; ld_sext = sext; ld_ena = 1'b1; end
      default: begin st_addr = a; st_len = len; st_data = d; st_ena = 1'b1; end
    endcase
    for (int k = 1; k <= 80 && !ok; k++) begin
      if (rand_rdy) rdy = ($urandom_range(0, 3) != 0);
      tick();
      if ((kind == 0 && if_done) || (kind == 1 && ld_done) || (kind == 2 && st_done)) begin
        ok = 1'b1; lat = k; data = (kind == 0) ? if_data : ld_data;
      end
    end
    if_ena = 1'b0; ld_ena = 1'b0; st_ena = 1'b0; rdy = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    n_tests++;
    if (mem_a !== 32'h0 || mem_dout !== 8'h00 || mem_wr !== 1'b0) begin
      n_fail++; $display("FAIL reset_bus: mem_a=%h dout=%h wr=%b, want 0", mem_a, mem_dout, mem_wr);
    end
    n_tests++;
    if ({if_done, ld_done, st_done} !== 3'b000) begin
      n_fail++; $display("FAIL reset_done: %b, want 000", {if_done, ld_done, st_done});
    end
    n_tests++;
    if (if_data !== 32'h0 || ld_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: if=%h ld=%h, want 0", if_data, ld_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_fetch;
    logic [31:0] want;
    ram[256] = 8'h13; ram[257] = 8'h05; ram[258] = 8'h00; ram[259] = 8'h00;
    want = exp_load(32'h100, 4, 1'b0);
    if_addr = 32'h100; if_ena = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_tests++;
      if (mem_a !== 32'h100 + 32'(k - 1) || if_done !== 1'b0) begin
        n_fail++; $display("FAIL fetch_addr%0d: mem_a=%h done=%b, want %h 0", k, mem_a, if_done, 32'h100 + 32'(k - 1));
      end
    end
    tick();
    n_tests++;
    if (if_done !== 1'b1 || if_data !== want || mem_a !== 32'h0) begin
      n_fail++; $display("FAIL fetch_done: done=%b data=%h mem_a=%h, want 1 %h 0", if_done, if_data, mem_a, want);
    end
    if_ena = 1'b0;
    tick();
    n_tests++;
    if (if_done !== 1'b0) begin
      n_fail++; $display("FAIL fetch_pulse: done=%b, want 0", if_done);
    end
  endtask

  task automatic test_load_sext;
    logic [31:0] data;
    int lat;
    bit ok;
    ram[32] = 8'h80;
    for (int s = 1; s >= 0; s--) begin
      run_req(1, 32'h20, 4'd0, s[0], 32'h0, 1'b0, data, lat, ok);
      n_tests++;
      if (!ok || lat != 2 || data !== exp_load(32'h20, 1, s[0])) begin
        n_fail++; $display("FAIL load_byte_sext%0d: ok=%0d lat=%0d data=%h, want lat 2 data %h", s, ok, lat, data, exp_load(32'h20, 1, s[0]));
      end
    end
  endtask

  task automatic test_store;
    int base;
    base = wlog.size();
    st_addr = 32'h40; st_len = 4'd1; st_data = 32'h0000BEEF; st_ena = 1'b1;
    tick();
    n_tests++;
    if (mem_wr !== 1'b1 || mem_a !== 32'h40 || mem_dout !== 8'hEF) begin
      n_fail++; $display("FAIL store_b0: wr=%b a=%h d=%h, want 1 40 EF", mem_wr, mem_a, mem_dout);
    end
    tick();
    n_tests++;
    if (mem_wr !== 1'b1 || mem_a !== 32'h41 || mem_dout !== 8'hBE) begin
      n_fail++; $display("FAIL store_b1: wr=%b a=%h d=%h, want 1 41 BE", mem_wr, mem_a, mem_dout);
    end
    tick();
    n_tests++;
    if (st_done !== 1'b1 || mem_wr !== 1'b0) begin
      n_fail++; $display("FAIL store_done: done=%b wr=%b, want 1 0", st_done, mem_wr);
    end
    st_ena = 1'b0;
    tick();
    n_tests++;
    if (wlog.size() != base + 2) begin
      n_fail++; $display("FAIL store_count: %0d writes, want 2", wlog.size() - base);
    end
  endtask

  task automatic test_priority;
    int st_c, ld_c, if_c;
    bit ld_g, if_g;
    logic [31:0] ldv, ifv;
    st_c = 0; ld_c = 0; if_c = 0; ld_g = 1'b0; if_g = 1'b0; ldv = 32'h0; ifv = 32'h0;
    st_addr = 32'h40; st_len = 4'd0; st_data = 32'h11;
    ld_addr = 32'h20; ld_len = 4'd0; ld_sext = 1'b0; if_addr = 32'h100;
    st_ena = 1'b1; ld_ena = 1'b1; if_ena = 1'b1;
    for (int c = 1; c <= 60 && if_c == 0; c++) begin
      tick();
      if (st_c != 0 && c == st_c + 2 && mem_a === 32'h20) ld_g = 1'b1;
      if (ld_c != 0 && c == ld_c + 2 && mem_a === 32'h100) if_g = 1'b1;
      if (st_done && st_c == 0) begin st_c = c; st_ena = 1'b0; end
      if (ld_done && ld_c == 0) begin ld_c = c; ld_ena = 1'b0; ldv = ld_data; end
      if (if_done && if_c == 0) begin if_c = c; if_ena = 1'b0; ifv = if_data; end
    end
    st_ena = 1'b0; ld_ena = 1'b0; if_ena = 1'b0;
    tick();
    n_tests++;
    if (!(st_c == 2 && ld_c > st_c && if_c > ld_c)) begin
      n_fail++; $display("FAIL prio_order: st=%0d ld=%0d if=%0d, want st=2<ld<if", st_c, ld_c, if_c);
    end
    n_tests++;
    if (!(ld_g && if_g)) begin
      n_fail++; $display("FAIL prio_cooldown: ld_grant=%0d if_grant=%0d, want 1 1", ld_g, if_g);
    end
    n_tests++;
    if (ldv !== exp_load(32'h20, 1, 1'b0) || ifv !== exp_load(32'h100, 4, 1'b0)) begin
      n_fail++; $display("FAIL prio_data: ld=%h if=%h, want %h %h", ldv, ifv, exp_load(32'h20, 1, 1'b0), exp_load(32'h100, 4, 1'b0));
    end
  endtask

  task automatic test_rollback_load;
    bit bad;
    logic [31:0] data;
    int lat;
    bit ok;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) ram[512 + i] = 8'(8'hA0 + i);
    ld_addr = 32'h200; ld_len = 4'd3; ld_sext = 1'b0; ld_ena = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (ld_done) bad = 1'b1;
    end
    rb = 1'b1;
    tick();
    n_tests++;
    if (mem_a !== 32'h0 || ld_done !== 1'b0 || bad) begin
      n_fail++; $display("FAIL rb_load_abort: mem_a=%h done=%b early=%0d, want 0 0 0", mem_a, ld_done, bad);
    end
    rb = 1'b0; ld_ena = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (ld_done !== 1'b0 || mem_a !== 32'h0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++; $display("FAIL rb_load_quiet: activity=%0d after abort, want 0", bad);
    end
    run_req(0, 32'h100, 4'd3, 1'b0, 32'h0, 1'b0, data, lat, ok);
    n_tests++;
    if (!ok || lat != 5 || data !== exp_load(32'h100, 4, 1'b0)) begin
      n_fail++; $display("FAIL rb_then_fetch: ok=%0d lat=%0d data=%h, want lat 5 %h", ok, lat, data, exp_load(32'h100, 4, 1'b0));
    end
  endtask

  task automatic test_rollback_store;
    int base;
    bit got, early, bad;
    logic [31:0] d, data;
    d = $urandom;
    base = wlog.size(); got = 1'b0; early = 1'b0; bad = 1'b0; data = 32'h0;
    rb = 1'b1;
    st_addr = 32'h80; st_len = 4'd3; st_data = d; st_ena = 1'b1;
    ld_addr = 32'h20; ld_len = 4'd0; ld_sext = 1'b0; ld_ena = 1'b1;
    for (int k = 1; k <= 20 && !got; k++) begin
      tick();
      if (st_done) got = 1'b1;
      if (ld_done) early = 1'b1;
    end
    st_ena = 1'b0;
    if (wlog.size() != base + 4) bad = 1'b1;
    else for (int i = 0; i < 4; i++)
      if (wlog[base + i] !== {32'h80 + 32'(i), d[8 * i +: 8]}) bad = 1'b1;
    n_tests++;
    if (!got || bad) begin
      n_fail++; $display("FAIL rb_store: done=%0d log_bad=%0d, want 1 0", got, bad);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      if (ld_done || mem_a === 32'h20) early = 1'b1;
    end
    n_tests++;
    if (early) begin
      n_fail++; $display("FAIL rb_blocks_ld: load served=%0d while rb high, want 0", early);
    end
    rb = 1'b0; got = 1'b0;
    for (int k = 1; k <= 20 && !got; k++) begin
      tick();
      if (ld_done) begin got = 1'b1; data = ld_data; end
    end
    ld_ena = 1'b0;
    tick();
    n_tests++;
    if (!got || data !== exp_load(32'h20, 1, 1'b0)) begin
      n_fail++; $display("FAIL rb_ld_after: done=%0d data=%h, want 1 %h", got, data, exp_load(32'h20, 1, 1'b0));
    end
  endtask

  task automatic test_io_backpressure;
    int base;
    base = wlog.size();
    io_buffer_full = 1'b1;
    st_addr = 32'h0003_0000; st_len = 4'd0; st_data = 32'h5A; st_ena = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_tests++;
      if (mem_wr !== 1'b0 || mem_a !== 32'h0003_0000 || st_done !== 1'b0) begin
        n_fail++; $display("FAIL io_stall%0d: wr=%b a=%h done=%b, want 0 30000 0", k, mem_wr, mem_a, st_done);
      end
    end
    io_buffer_full = 1'b0;
    tick();
    n_tests++;
    if (mem_wr !== 1'b1 || mem_a !== 32'h0003_0000 || mem_dout !== 8'h5A) begin
      n_fail++; $display("FAIL io_write: wr=%b a=%h d=%h, want 1 30000 5A", mem_wr, mem_a, mem_dout);
    end
    tick();
    st_ena = 1'b0;
    n_tests++;
    if (st_done !== 1'b1 || wlog.size() != base + 1) begin
      n_fail++; $display("FAIL io_done: done=%b writes=%0d, want 1 1", st_done, wlog.size() - base);
    end
    tick();
  endtask

  task automatic test_rdy_freeze;
    int base;
    base = wlog.size();
    st_addr = 32'h60; st_len = 4'd1; st_data = 32'h0000_C3A5; st_ena = 1'b1;
    tick();
    rdy = 1'b0;
    #1;
    n_tests++;
    if (mem_wr !== 1'b0) begin
      n_fail++; $display("FAIL rdy_gate: wr=%b with rdy low, want 0", mem_wr);
    end
    for (int k = 0; k < 3; k++) tick();
    n_tests++;
    if (mem_a !== 32'h60 || mem_dout !== 8'hA5 || st_done !== 1'b0) begin
      n_fail++; $display("FAIL rdy_hold: a=%h d=%h done=%b, want 60 A5 0", mem_a, mem_dout, st_done);
    end
    rdy = 1'b1;
    #1;
    tick(); tick();
    st_ena = 1'b0;
    n_tests++;
    if (st_done !== 1'b1 || wlog.size() != base + 2 ||
        wlog[base] !== {32'h60, 8'hA5} || wlog[base + 1] !== {32'h61, 8'hC3}) begin
      n_fail++; $display("FAIL rdy_resume: done=%b writes=%0d, want 1 2 (60:A5 61:C3)", st_done, wlog.size() - base);
    end
    tick();
  endtask

  task automatic test_random;
    int kind, nb, lat, base;
    bit ok, bad;
    logic [31:0] a, d, data, want;
    logic [3:0] len;
    logic sext;
    for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);
    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 2);
      a = 32'($urandom_range(0, 1000));
      case ($urandom_range(0, 2))
        0:       len = 4'd0;
        1:       len = 4'd1;
        default: len = 4'd3;
      endcase
      sext = 1'($urandom);
      d = $urandom;
      nb = (kind == 0) ? 4 : int'(len) + 1;
      base = wlog.size();
      run_req(kind, a, len, sext, d, 1'b1, data, lat, ok);
      n_tests++;
      if (!ok) begin
        n_fail++; $display("FAIL rand%0d_timeout: kind=%0d addr=%h no done", n, kind, a);
      end else if (kind == 2) begin
        bad = (wlog.size() != base + nb);
        if (!bad)
          for (int i = 0; i < nb; i++)
            if (wlog[base + i] !== {a + 32'(i), d[8 * i +: 8]}) bad = 1'b1;
        if (bad) begin
          n_fail++; $display("FAIL rand%0d_store: addr=%h len=%0d writes=%0d, want %0d exact bytes", n, a, len, wlog.size() - base, nb);
        end
      end else begin
        want = exp_load(a, nb, (kind == 1) ? sext : 1'b0);
        if (data !== want) begin
          n_fail++; $display("FAIL rand%0d_read: kind=%0d addr=%h len=%0d sext=%b got=%h want=%h", n, kind, a, len, sext, data, want);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; rb = 1'b0; io_buffer_full = 1'b0;
    if_ena = 1'b0; if_addr = 32'h0;
    ld_ena = 1'b0; ld_addr = 32'h0; ld_len = 4'd0; ld_sext = 1'b0;
    st_ena = 1'b0; st_addr = 32'h0; st_len = 4'd0; st_data = 32'h0;
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    test_reset();
    test_fetch();
    test_load_sext();
    test_store();
    test_priority();
    test_rollback_load();
    test_rollback_store();
    test_io_backpressure();
    test_rdy_freeze();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Single-port memory controller that shares the byte-wide RAM/IO port between three requesters: instruction fetch (IF), the store/load buffer's load channel (LD) and its store channel (ST).
- Serialises each multi-byte access into byte transactions.
- Assembles and extends load data, and returns a one-cycle done pulse to the requester.
- Sits between the fetch unit / SLB and the top-level RAM/IO bus.

Parameters:
ADDR_W, 32, byte address width
IO_HI, 2'b11, value of addr[17:16] that selects the IO region

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global ready; low freezes the block
rb  in  1  rollback; aborts IF/LD, never ST
if_ena  in  1  fetch request, level-held until if_done
if_addr  in  32  fetch address
if_done  out  1  one-cycle pulse, if_data valid
if_data  out  32  fetched word
ld_ena  in  1  load request, level-held until ld_done
ld_addr  in  32  load address
ld_len  in  4  bytes-1 (0, 1 or 3)
ld_sext  in  1  sign-extend load result
ld_done  out  1  one-cycle pulse, ld_data valid
ld_data  out  32  extended load result
st_ena  in  1  store request, level-held until st_done
st_addr  in  32  store address
st_len  in  4  bytes-1 (0, 1 or 3)
st_data  in  32  store data, little-endian
st_done  out  1  one-cycle pulse, store complete
mem_din  in  8  RAM read byte
mem_dout  out  8  RAM write byte
mem_a  out  32  RAM byte address
mem_wr  out  1  write strobe
io_buffer_full  in  1  IO sink cannot accept a byte

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - state=IDLE, cnt=0.
  - mem_a=0, mem_dout=0, mem_wr=0.
  - all done pulses 0; if_data=0, ld_data=0.
- rdy low: all registers hold; mem_wr output is gated to 0 combinationally.
- States:
  - IDLE, FETCH, LOAD, STORE.
  - Latched request fields are addr, L=len+1, sext and data; FETCH always uses L=4.
- Grant, only in IDLE:
  - No grant in any cycle where a done pulse is high (one-cycle cooldown, so a requester can drop ena).
  - Priority is st_ena > ld_ena > if_ena.
- Read timing (FETCH/LOAD), RAM read latency 1:
  - Grant edge E0 drives mem_a=addr.
  - Edge Ek (1≤k≤L) captures mem_din into byte k-1 and drives mem_a=addr+k while k<L.
  - At E_L: assert done and data, return to IDLE, mem_a=0.
  - Done is visible L+1 cycles after grant.
- Store timing:
  - Edge Ek (0≤k<L) drives mem_a=addr+k, mem_dout=st_data[8k+7:8k], mem_wr=1.
  - At E_L: mem_wr=0, st_done=1, return to IDLE.
- IO back-pressure: while in STORE with addr[17:16]==IO_HI and io_buffer_full=1, cnt does not advance and mem_wr=0; the pending byte is retried.
- Load extension:
  - len 0: 8 bits, sext replicates bit 7.
  - len 1: 16 bits, sext replicates bit 15.
  - len 3: word, sext ignored.
  - Unsigned zero-fills.
- Rollback (rb=1):
  - FETCH/LOAD go to IDLE, mem_a=0, no done pulse, partial data discarded.
  - STORE continues to completion and st_done still pulses.
  - No new grant to IF/LD while rb=1; a pending ST may be granted.
- Simultaneous requests: losers stay pending, served in priority order after the cooldown cycle.
- Requester dropping ena mid-access is illegal; the access completes regardless.

Decomposition:
- Shared utils header: `ADDR_TP, `WORD_TP, `TRUE/`FALSE, `ZERO_WORD, `ZERO_ADDR.
- State encodings and IO_HI are local parameters.
- One sub-module: load_extender (combinational; inputs raw 32-bit word, len, sext; output extended word), instantiated for ld_data.

Test Plan:
- Reset, then if_ena=1, if_addr=0x100, RAM bytes 0x13,0x05,0x00,0x00 -> mem_a 0x100..0x103 on consecutive cycles; if_done 5 cycles after grant with if_data=0x00000513.
- ld_ena with ld_addr=0x20, len=0, sext=1, byte 0x80 -> ld_data=0xFFFFFF80. Repeat with sext=0 -> ld_data=0x00000080.
- st_ena, st_addr=0x40, len=1, st_data=0x0000BEEF -> mem_wr=1 at 0x40=0xEF then 0x41=0xBE; st_done next cycle.
- st_ena, ld_ena and if_ena all asserted together -> ST served first, then one cooldown cycle, then LD, then IF.
- LOAD len=3 in progress, rb=1 at byte 2 -> no ld_done, IDLE next cycle. Same rb during STORE -> all bytes written, st_done pulses.
- Store to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr=0 and mem_a held; byte written the cycle after full drops.
